// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into one-cycle gesture pulses
// (short press, long press, double click) plus held/busy status levels.
module button_press_classifier #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int CNT_W       = $clog2(((LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    HELD,
    GAP,
    PRESSED2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             short_press_q, short_press_d;
  logic             long_press_q, long_press_d;
  logic             double_click_q, double_click_d;
  logic             held_q, held_d;
  logic             busy_q, busy_d;
  logic             rise;

  assign rise = btn & ~btn_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    btn_d          = btn;
    short_press_d  = 1'b0;
    long_press_d   = 1'b0;
    double_click_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (!btn) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LONG_CYCLES - 1)) begin
          long_press_d = 1'b1;
          state_d      = HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn) state_d = IDLE;
      end
      GAP: begin
        // A second press on the final gap edge beats the short-press timeout.
        if (btn) begin
          state_d = PRESSED2;
        end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          short_press_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED2: begin
        if (!btn) begin
          double_click_d = 1'b1;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == HELD);
    busy_d = (state_d != IDLE);
  end

  // btn_q resets high so a button held through reset must be released first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      btn_q          <= 1'b1;
      short_press_q  <= 1'b0;
      long_press_q   <= 1'b0;
      double_click_q <= 1'b0;
      held_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      btn_q          <= btn_d;
      short_press_q  <= short_press_d;
      long_press_q   <= long_press_d;
      double_click_q <= double_click_d;
      held_q         <= held_d;
      busy_q         <= busy_d;
    end
  end

  assign short_press  = short_press_q;
  assign long_press   = long_press_q;
  assign double_click = double_click_q;
  assign held         = held_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier: directed gesture scenarios
// followed by random press/release runs, compared against a timestamp-based model.
module tb_button_press_classifier;

  localparam int LONG = 8;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic short_press, long_press, double_click, held, busy;

  int checks = 0;
  int failures = 0;

  // Model state: edge counter plus timestamps of the gesture in progress.
  int  t = 0;
  int  rise_t = -1;
  int  rel_t = -1;
  bit  second = 0;
  bit  long_done = 0;
  bit  prev_btn = 1;
  bit  exp_short, exp_long, exp_double, exp_held, exp_busy;

  button_press_classifier #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .held        (held),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic clearGesture();
    rise_t    = -1;
    rel_t     = -1;
    second    = 0;
    long_done = 0;
  endtask

  // Reference: decide each edge from how long ago the press/release happened.
  task automatic modelStep(input bit b, input bit r);
    exp_short  = 0;
    exp_long   = 0;
    exp_double = 0;
    if (r) begin
      clearGesture();
      prev_btn = 1;
    end else begin
      if (rise_t < 0) begin
        if (b && !prev_btn) rise_t = t;
      end else if (second) begin
        if (!b) begin
          exp_double = 1;
          clearGesture();
        end
      end else if (rel_t < 0) begin
        if (long_done) begin
          if (!b) clearGesture();
        end else if (!b) begin
          rel_t = t;
        end else if (t - rise_t == LONG) begin
          exp_long  = 1;
          long_done = 1;
        end
      end else begin
        if (b) second = 1;
        else if (t - rel_t == GAP) begin
          exp_short = 1;
          clearGesture();
        end
      end
      prev_btn = b;
    end
    exp_busy = (rise_t >= 0);
    exp_held = long_done;
    t++;
  endtask

  task automatic checkOne(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, expv);
    end
  endtask

  task automatic checkOutput();
    checkOne("short_press", short_press, exp_short);
    checkOne("long_press", long_press, exp_long);
    checkOne("double_click", double_click, exp_double);
    checkOne("held", held, exp_held);
    checkOne("busy", busy, exp_busy);
  endtask

  task automatic applyStimulus(input bit b, input bit r, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      btn   = b;
      reset = r;
      @(posedge clk);
      modelStep(b, r);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    btn   = 1'b1;
    reset = 1'b1;

    $display("[TB] scenario 1: button held through reset");
    applyStimulus(1, 1, 2);
    applyStimulus(1, 0, 20);
    applyStimulus(0, 0, 10);

    $display("[TB] scenario 2: short press");
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 8);

    $display("[TB] scenario 3: long press and held");
    applyStimulus(1, 0, 20);
    applyStimulus(0, 0, 6);

    $display("[TB] scenario 4: double click");
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 2);
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 6);

    $display("[TB] scenario 5: gap boundary");
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 4);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 7);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 5);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 7);

    $display("[TB] scenario 6: reset while held");
    applyStimulus(1, 0, 12);
    applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 10);
    applyStimulus(0, 0, 3);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 7);

    $display("[TB] random runs");
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        applyStimulus(bit'($urandom_range(0, 1)), 1, 1);
      end else begin
        applyStimulus(bit'(k % 2), 0, $urandom_range(1, 11));
      end
    end
    applyStimulus(0, 0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
